// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one memory read cycle among NREQ requesters.
// One-hot FSM with every output taken straight from a flop.
module mem_rd_arbiter #(
    parameter int NREQ   = 2,
    parameter int WS_MAX = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            ws,
    output logic [NREQ-1:0] gnt,
    output logic            rd,
    output logic            ds,
    output logic [NREQ-1:0] done,
    output logic            timeout,
    output logic            busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WS_MAX + 1);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        READ = 4'b0010,
        DLY  = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            rd_q, rd_d;
    logic            ds_q, ds_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_owner_q, last_owner_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    logic [IW-1:0]   cand_idx;
    logic [IW-1:0]   win_idx;
    logic            win_vld;
    logic [NREQ-1:0] win_oh;

    // Search starts one past the previous owner so a winner yields to everyone else.
    always_comb begin
        win_idx  = '0;
        win_vld  = 1'b0;
        cand_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_idx = IW'((int'(last_owner_q) + 1 + i) % NREQ);
            if (!win_vld && req[cand_idx]) begin
                win_idx = cand_idx;
                win_vld = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_win_oh
            assign win_oh[gi] = win_vld && (win_idx == IW'(gi));
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (win_vld) begin
                    state_d    = READ;
                    gnt_d      = win_oh;
                    owner_d    = win_idx;
                    wait_cnt_d = '0;
                end
            end
            READ: state_d = DLY;
            DLY: begin
                if (ws) begin
                    if (wait_cnt_q < CW'(WS_MAX)) begin
                        state_d    = READ;
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end else begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d      = IDLE;
                gnt_d        = '0;
                last_owner_d = owner_q;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        // Outputs are decoded from the next state and registered alongside it.
        rd_d   = (state_d == READ) || (state_d == DLY);
        ds_d   = (state_d == DONE);
        done_d = ds_d ? gnt_d : '0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            done_q       <= '0;
            rd_q         <= 1'b0;
            ds_q         <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            owner_q      <= '0;
            last_owner_q <= IW'(NREQ - 1);
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            rd_q         <= rd_d;
            ds_q         <= ds_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rd      = rd_q;
    assign ds      = ds_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter with NREQ=2, WS_MAX=4.
module tb_mem_rd_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic       ws = 1'b0;
    logic [1:0] gnt;
    logic       rd;
    logic       ds;
    logic [1:0] done;
    logic       timeout;
    logic       busy;
    logic [7:0] obs;

    int total = 0;
    int bad   = 0;

    mem_rd_arbiter #(.NREQ(2), .WS_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .ws(ws),
        .gnt(gnt), .rd(rd), .ds(ds), .done(done),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // {gnt, rd, ds, done, timeout, busy}
    assign obs = {gnt, rd, ds, done, timeout, busy};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = 2'b00;
        ws = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (obs !== 8'b0) begin
            $display("FAIL reset_outputs obs=%b expected=%b", obs, 8'b0);
            bad++;
        end
        do_reset();
        tick();
        total++;
        if (obs !== 8'b0) begin
            $display("FAIL reset_idle obs=%b expected=%b", obs, 8'b0);
            bad++;
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_t [5];
        exp_t[0] = 8'b01_1_0_00_0_1;
        exp_t[1] = 8'b01_1_0_00_0_1;
        exp_t[2] = 8'b01_0_1_01_0_1;
        exp_t[3] = 8'b00_0_0_00_0_0;
        exp_t[4] = 8'b00_0_0_00_0_0;
        do_reset();
        req = 2'b01;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (obs !== exp_t[c]) begin
                $display("FAIL basic_cycle%0d obs=%b expected=%b", c + 1, obs, exp_t[c]);
                bad++;
            end
            if (c == 2) req = 2'b00;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_v;
        do_reset();
        req = 2'b11;
        for (int c = 0; c < 16; c++) begin
            tick();
            if ((c % 4) == 3)
                exp_v = 3'b000;
            else if (((c / 4) % 2) == 0)
                exp_v = {2'b01, (c % 4) == 2};
            else
                exp_v = {2'b10, (c % 4) == 2};
            total++;
            if ({gnt, ds} !== exp_v) begin
                $display("FAIL rr_cycle%0d gnt_ds=%b expected=%b", c + 1, {gnt, ds}, exp_v);
                bad++;
            end
            if (c == 14) req = 2'b00;
        end
    endtask

    task automatic test_wait_states();
        int rd_n = 0;
        int ds_n = 0;
        int to_n = 0;
        do_reset();
        req = 2'b01;
        ws = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            rd_n += int'(rd);
            ds_n += int'(ds);
            to_n += int'(timeout);
            if (c == 4) ws = 1'b0;
            if (c == 6) begin
                total++;
                if ({ds, done} !== 3'b101) begin
                    $display("FAIL ws_done_cycle ds_done=%b expected=%b", {ds, done}, 3'b101);
                    bad++;
                end
                req = 2'b00;
            end
        end
        total++;
        if (rd_n != 6) begin
            $display("FAIL ws_rd_cycles got=%0d expected=6", rd_n);
            bad++;
        end
        total++;
        if (ds_n != 1 || to_n != 0) begin
            $display("FAIL ws_ds_timeout ds=%0d timeout=%0d expected ds=1 timeout=0", ds_n, to_n);
            bad++;
        end
    endtask

    task automatic test_timeout();
        int rd_n = 0;
        do_reset();
        req = 2'b01;
        ws = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            rd_n += int'(rd);
            if (c == 10) begin
                total++;
                if ({ds, timeout, rd} !== 3'b110) begin
                    $display("FAIL to_pulse ds_to_rd=%b expected=%b", {ds, timeout, rd}, 3'b110);
                    bad++;
                end
                req = 2'b00;
                ws = 1'b0;
            end
            if (c == 11) begin
                total++;
                if ({busy, timeout} !== 2'b00) begin
                    $display("FAIL to_idle busy_to=%b expected=%b", {busy, timeout}, 2'b00);
                    bad++;
                end
            end
        end
        total++;
        if (rd_n != 10) begin
            $display("FAIL to_rd_cycles got=%0d expected=10", rd_n);
            bad++;
        end
    endtask

    task automatic test_req_drop();
        int extra = 0;
        do_reset();
        req = 2'b10;
        tick();
        total++;
        if (gnt !== 2'b10) begin
            $display("FAIL drop_gnt gnt=%b expected=%b", gnt, 2'b10);
            bad++;
        end
        req = 2'b00;
        tick();
        tick();
        total++;
        if ({ds, done} !== 3'b110) begin
            $display("FAIL drop_done ds_done=%b expected=%b", {ds, done}, 3'b110);
            bad++;
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (busy || gnt != 2'b00) extra++;
        end
        total++;
        if (extra != 0) begin
            $display("FAIL drop_no_regrant busy_cycles=%0d expected=0", extra);
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        int ds_seen = 0;
        do_reset();
        req = 2'b01;
        ws = 1'b1;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (obs !== 8'b0) begin
            $display("FAIL midrst_async obs=%b expected=%b", obs, 8'b0);
            bad++;
        end
        req = 2'b11;
        ws = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            ds_seen += int'(ds) + int'(done != 2'b00);
        end
        total++;
        if (ds_seen != 0) begin
            $display("FAIL midrst_no_ds count=%0d expected=0", ds_seen);
            bad++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        total++;
        if ({gnt, rd} !== 3'b011) begin
            $display("FAIL midrst_regrant gnt_rd=%b expected=%b", {gnt, rd}, 3'b011);
            bad++;
        end
        req = 2'b00;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wait_states();
        test_timeout();
        test_req_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing the memory read cycle, legal range 2..8.
REQ-002 Parameter WS_MAX, default 4: maximum wait-state extensions per transaction before forced completion, legal range 1..15.
REQ-003 clk  input  1: single clock; all flops rising-edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 req  input  NREQ: per-requester read request, level, held until matching done.
REQ-006 ws  input  1: memory wait-state request, sampled in DLY.
REQ-007 gnt  output  NREQ: one-hot grant to the current owner.
REQ-008 rd  output  1: memory read strobe.
REQ-009 ds  output  1: data-strobe / read-complete, one-cycle pulse.
REQ-010 done  output  NREQ: one-hot completion pulse to the owner, coincident with ds.
REQ-011 timeout  output  1: one-cycle pulse with ds when completion was forced by WS_MAX.
REQ-012 busy  output  1: high whenever state is not IDLE.

Function
REQ-013 FSM states IDLE, READ, DLY, DONE; state one-hot encoded.
REQ-014 All outputs driven directly from flops, never from combinational decode, so every output is glitch-free.
REQ-015 IDLE: if any req bit is high at an edge, the FSM goes to READ, latches the winner into gnt, and clears wait_cnt; otherwise it stays in IDLE with gnt=0.
REQ-016 READ: rd=1; the FSM goes to DLY unconditionally.
REQ-017 DLY: rd=1; if ws=1 and wait_cnt<WS_MAX, the FSM goes to READ and wait_cnt increments; if ws=1 and wait_cnt==WS_MAX, it goes to DONE with timeout set; if ws=0, it goes to DONE.
REQ-018 DONE: ds=1, done=gnt, timeout per REQ-017; the FSM goes to IDLE unconditionally; gnt clears on leaving DONE.
REQ-019 rd is 0 in IDLE and DONE; ds, done and timeout are 0 outside DONE.
REQ-020 wait_cnt width is clog2(WS_MAX+1) and never wraps.
REQ-021 Latency with ws=0: req sampled at edge T gives rd high during cycles T+1 and T+2, ds/done high during cycle T+3, and IDLE during cycle T+4.
REQ-022 Each ws extension adds 2 rd cycles; the maximum transaction is 3+2*WS_MAX cycles after the grant edge.
REQ-023 Minimum spacing between consecutive grants is 4 cycles; a req still high in IDLE is re-arbitrated.
REQ-024 Arbitration is round-robin: the search starts at (last_owner+1) mod NREQ, and the first set req bit wins.
REQ-025 last_owner updates in DONE only.
REQ-026 A requester that wins is not granted again while any other requester holds req.
REQ-027 req deassertion after the grant is ignored: the transaction completes normally and done still pulses to the owner.
REQ-028 gnt is stable for the whole transaction; changes on req and ws outside IDLE and DLY respectively are ignored.
REQ-029 Simultaneous requests: exactly one grant is issued; never more than one gnt bit is high.

Reset
REQ-030 reset_n low forces, immediately and asynchronously: state=IDLE, gnt=0, rd=0, ds=0, done=0, timeout=0, busy=0, wait_cnt=0.
REQ-031 After reset, last_owner=NREQ-1, so requester 0 has first priority.
REQ-032 Reset asserted mid-transaction aborts it with no ds or done pulse; the first edge after reset_n rises samples req in IDLE.

Verification
REQ-033 Reset, then req=01, ws=0: gnt=01, rd=1 for 2 cycles, then ds=1 and done=01 for 1 cycle, then busy=0; timeout stays 0.
REQ-034 req=11 held, ws=0, 4 transactions: grant order 01, 10, 01, 10, each transaction exactly 4 cycles apart.
REQ-035 req=01 with ws=1 for 2 DLY samples then 0: rd high for 6 cycles, single ds pulse, timeout=0.
REQ-036 ws held 1 with WS_MAX=4: rd high for 10 cycles, then ds=1 and timeout=1 together for 1 cycle, then IDLE.
REQ-037 req=10 granted, req dropped to 00 during READ: done=10 still pulses, with no new grant afterwards.
REQ-038 reset_n pulsed low during DLY: all outputs 0 immediately, no ds; with req=11 after release, gnt=01.
